// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding, parity constants and parity helper for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic calc_parity(input logic [8:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two circular FIFO with occupancy count, flushed by async reset
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_ready = r_count != (AW+1)'(DEPTH);

  // storage array; contents need no reset since the count gates every read
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  // pointers wrap naturally at DEPTH; count tracks push/pop balance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= i_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= i_pop ? r_rd + 1'b1 : r_rd;
      r_count <= (i_push && !i_pop) ? r_count + 1'b1 :
                 (i_pop && !i_push) ? r_count - 1'b1 : r_count;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parameterised UART transmitter with transmit FIFO, optional parity and 1/2 stop bits
module uart_tx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 20,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          s_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import uart_pkg::*;

  localparam int BW = $clog2(CLK_DIV);
  localparam logic ODD = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;

  uart_state_e          r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_baud_done;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic [DATA_BITS-1:0] w_head;

  assign w_push     = s_valid && s_ready;
  assign uart_tx    = r_tx;
  assign busy       = r_state != ST_IDLE;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (s_data),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_count(fifo_count),
    .o_ready(s_ready)
  );

  // bit-period boundaries and the pop decision: start from IDLE, or chain straight out of the last stop bit
  always_comb begin
    w_baud_done = r_baud == BW'(CLK_DIV-1);
    w_last_data = r_bit == 4'(DATA_BITS-1);
    w_last_stop = r_bit == 4'(STOP_BITS-1);
    w_pop       = (fifo_count != '0) &&
                  (r_state == ST_IDLE || (r_state == ST_STOP && w_baud_done && w_last_stop));
  end

  // frame sequencer: baud counter, bit counter, LSB-first shift register and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else if (w_pop) begin
      r_state <= ST_START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= w_head;
      r_par   <= calc_parity(9'(w_head), ODD);
      r_tx    <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_baud  <= '0;
      r_tx    <= 1'b1;
    end else if (!w_baud_done) begin
      r_baud  <= r_baud + 1'b1;
    end else begin
      r_baud  <= '0;
      case (r_state)
        ST_START: begin
          r_state <= ST_DATA;
          r_bit   <= '0;
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
        end
        ST_DATA: begin
          if (w_last_data) begin
            r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            r_bit   <= '0;
            r_tx    <= (PARITY_EN != 0) ? r_par : 1'b1;
          end else begin
            r_bit   <= r_bit + 1'b1;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
          r_bit   <= '0;
          r_tx    <= 1'b1;
        end
        ST_STOP: begin
          r_state <= w_last_stop ? ST_IDLE : ST_STOP;
          r_bit   <= w_last_stop ? '0 : r_bit + 1'b1;
          r_tx    <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed frame vectors over four configurations plus FIFO-full and mid-frame reset sequences
module tb_uart_tx_cfg;

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic [11:0] exp;
    int         nb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sv  = '0;
  logic [3:0] rdy;
  logic [3:0] tx;
  logic [3:0] bsy;
  logic [7:0] sd0 = '0;
  logic [7:0] sd1 = '0;
  logic [7:0] sd2 = '0;
  logic [6:0] sd3 = '0;
  logic [2:0] cnt [4];
  int         vectors = 0;
  int         errors  = 0;
  vec_t       tbl [9];
  logic [7:0] w [6];

  always #5 clk = ~clk;

  uart_tx_cfg u_d0 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_data(sd0), .s_ready(rdy[0]),
    .uart_tx(tx[0]), .busy(bsy[0]), .fifo_count(cnt[0])
  );

  uart_tx_cfg #(.PARITY_EN(1), .PARITY_ODD(0)) u_d1 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_data(sd1), .s_ready(rdy[1]),
    .uart_tx(tx[1]), .busy(bsy[1]), .fifo_count(cnt[1])
  );

  uart_tx_cfg #(.PARITY_EN(1), .PARITY_ODD(1)) u_d2 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_data(sd2), .s_ready(rdy[2]),
    .uart_tx(tx[2]), .busy(bsy[2]), .fifo_count(cnt[2])
  );

  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u_d3 (
    .clk(clk), .rst(rst), .s_valid(sv[3]), .s_data(sd3), .s_ready(rdy[3]),
    .uart_tx(tx[3]), .busy(bsy[3]), .fifo_count(cnt[3])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_data(input int inst, input logic [8:0] d);
    case (inst)
      0: sd0 = d[7:0];
      1: sd1 = d[7:0];
      2: sd2 = d[7:0];
      default: sd3 = d[6:0];
    endcase
  endtask

  task automatic send(input int inst, input logic [8:0] d, input logic [11:0] exp, input int nb);
    @(negedge clk);
    set_data(inst, d);
    sv[inst] = 1'b1;
    @(posedge clk); #1;
    sv[inst] = 1'b0;
    check($sformatf("inst%0d idle at accept", inst), 32'(tx[inst]), 32'd1);
    @(posedge clk); #1;
    check($sformatf("inst%0d start latency", inst), 32'(tx[inst]), 32'd0);
    check($sformatf("inst%0d busy at start", inst), 32'(bsy[inst]), 32'd1);
    for (int k = 0; k < nb; k++) begin
      repeat (k == 0 ? 10 : 20) @(posedge clk);
      #1;
      check($sformatf("inst%0d data %0h bit%0d", inst, d, k), 32'(tx[inst]), 32'(exp[k]));
    end
    repeat (9) @(posedge clk);
    #1;
    check($sformatf("inst%0d busy last cycle", inst), 32'(bsy[inst]), 32'd1);
    @(posedge clk); #1;
    check($sformatf("inst%0d busy falls", inst), 32'(bsy[inst]), 32'd0);
    check($sformatf("inst%0d fifo empty", inst), 32'(cnt[inst]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_bad;
    tbl[0] = '{0, 9'h0A5, 12'({1'b1, 8'hA5, 1'b0}), 10};
    tbl[1] = '{0, 9'h000, 12'({1'b1, 8'h00, 1'b0}), 10};
    tbl[2] = '{0, 9'h0FF, 12'({1'b1, 8'hFF, 1'b0}), 10};
    tbl[3] = '{1, 9'h007, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11};
    tbl[4] = '{2, 9'h007, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11};
    tbl[5] = '{1, 9'h000, 12'({1'b1, 1'b0, 8'h00, 1'b0}), 11};
    tbl[6] = '{2, 9'h000, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
    tbl[7] = '{3, 9'h055, 12'({2'b11, 7'h55, 1'b0}), 10};
    tbl[8] = '{1, 9'h0A5, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11};
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    repeat (3) @(posedge clk);
    #1;
    check("reset tx", 32'(tx), 32'hF);
    check("reset busy", 32'(bsy), 32'h0);
    check("reset ready", 32'(rdy), 32'hF);
    check("reset count", 32'(cnt[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle line high", 32'(tx), 32'hF);

    for (int i = 0; i < 9; i++) send(tbl[i].inst, tbl[i].d, tbl[i].exp, tbl[i].nb);

    @(negedge clk);
    sv[0] = 1'b1;
    sd0   = w[0];
    @(posedge clk); #1;
    sd0 = w[1];
    check("burst idle at E0", 32'(tx[0]), 32'd1);
    @(posedge clk); #1;
    check("burst start at E1", 32'(tx[0]), 32'd0);
    fork
      begin
        logic [9:0] fr;
        for (int f = 0; f < 6; f++) begin
          fr = {1'b1, w[f], 1'b0};
          for (int k = 0; k < 10; k++) begin
            repeat ((f == 0 && k == 0) ? 10 : 20) @(posedge clk);
            #1;
            check($sformatf("burst frame%0d bit%0d", f, k), 32'(tx[0]), 32'(fr[k]));
          end
        end
        repeat (9) @(posedge clk);
        #1;
        check("burst busy before end", 32'(bsy[0]), 32'd1);
        @(posedge clk); #1;
        check("burst busy falls", 32'(bsy[0]), 32'd0);
        check("burst fifo drained", 32'(cnt[0]), 32'd0);
      end
      begin
        sd0 = w[2];
        @(posedge clk); #1;
        sd0 = w[3];
        @(posedge clk); #1;
        sd0 = w[4];
        @(posedge clk); #1;
        check("burst count full", 32'(cnt[0]), 32'd4);
        check("burst ready low on 6th", 32'(rdy[0]), 32'd0);
        sd0 = w[5];
        repeat (196) @(posedge clk);
        #1;
        check("burst ready low till frame end", 32'(rdy[0]), 32'd0);
        @(posedge clk); #1;
        check("burst pop at frame end", 32'(cnt[0]), 32'd3);
        check("burst ready after pop", 32'(rdy[0]), 32'd1);
        @(posedge clk); #1;
        check("burst 6th accepted", 32'(cnt[0]), 32'd4);
        sv[0] = 1'b0;
      end
    join

    @(negedge clk);
    sv[0] = 1'b1;
    sd0   = 8'h00;
    @(posedge clk); #1;
    sd0 = 8'h81;
    @(posedge clk); #1;
    sd0 = 8'h42;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    check("abort pre tx low", 32'(tx[0]), 32'd0);
    check("abort pre queued", 32'(cnt[0]), 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort tx async high", 32'(tx[0]), 32'd1);
    check("abort busy", 32'(bsy[0]), 32'd0);
    check("abort flush", 32'(cnt[0]), 32'd0);
    check("abort ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) quiet_bad++;
    end
    check("abort no further frames", 32'(quiet_bad), 32'd0);

    send(0, 9'h03C, 12'({1'b1, 8'h3C, 1'b0}), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, sets the data bits per frame; legal range 5..9.
REQ-002 Parameter CLK_DIV, default 20, sets the clk cycles per UART bit; legal range >= 2.
REQ-003 Parameter PARITY_EN, default 0, adds a parity bit after the data bits when set to 1.
REQ-004 Parameter PARITY_ODD, default 0, selects parity type: 0 = even, 1 = odd; ignored when PARITY_EN = 0.
REQ-005 Parameter STOP_BITS, default 1, sets the stop-bit count; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 4, sets the transmit FIFO depth; must be a power of 2, >= 2.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 s_valid  input  1  write request from the producer.
REQ-010 s_data  input  DATA_BITS  word to transmit.
REQ-011 s_ready  output  1  FIFO can accept a word this cycle.
REQ-012 uart_tx  output  1  serial line, idle high, registered.
REQ-013 busy  output  1  a frame is in progress (FSM not IDLE).
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words stored in the FIFO.

Function
REQ-015 A word SHALL be accepted on a rising edge where s_valid = 1 and s_ready = 1; s_data is ignored otherwise.
REQ-016 s_ready SHALL be 0 exactly when fifo_count == FIFO_DEPTH; it depends on registered state only, not on s_valid.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN = 1.
REQ-018 In IDLE with fifo_count > 0, the next edge SHALL pop the head word, enter START and drive uart_tx = 0.
REQ-019 Worst-case latency SHALL be 2 edges: a word written at edge E into an empty FIFO with the FSM in IDLE drives uart_tx low from edge E+1.
REQ-020 A baud counter SHALL count 0..CLK_DIV-1, reset to 0 on every frame start, and be held at 0 in IDLE; each bit lasts exactly CLK_DIV cycles.
REQ-021 Data bits SHALL be sent LSB first, one per bit period, with DATA_BITS periods in DATA.
REQ-022 The parity bit SHALL equal XOR of the data bits, inverted when PARITY_ODD = 1.
REQ-023 STOP SHALL drive uart_tx = 1 for STOP_BITS x CLK_DIV cycles.
REQ-024 Frame length SHALL be (1 + DATA_BITS + PARITY_EN + STOP_BITS) x CLK_DIV cycles.
REQ-025 At the end of STOP, if fifo_count > 0 the FSM SHALL pop and enter START on the same edge, leaving no idle gap; otherwise it enters IDLE.
REQ-026 On a simultaneous push and pop, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-027 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; words SHALL leave in write order.
REQ-028 A pop SHALL never occur with fifo_count == 0; an empty FIFO in IDLE holds uart_tx = 1.

Reset
REQ-029 While rst = 1, the block SHALL drive uart_tx = 1, busy = 0, fifo_count = 0 and s_ready = 1, and hold the FSM in IDLE with the baud counter at 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (uart_tx = 1 asynchronously) and flush the FIFO contents.
REQ-031 After rst deasserts, the first accepted word SHALL follow REQ-019 timing.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state enum and constants PARITY_EVEN / PARITY_ODD.
REQ-033 The FIFO SHALL be a separate sub-module uart_tx_fifo, parametrised on WIDTH and DEPTH; the FSM, baud counter and shift register reside in uart_tx_cfg.

Verification
REQ-034 Defaults (8N1, CLK_DIV = 20), push 0xA5 -> uart_tx 0,1,0,1,0,0,1,0,1,1, each held 20 cycles; busy falls after 200 cycles.
REQ-035 PARITY_EN = 1, even parity, push 0x07 -> parity bit 1; with PARITY_ODD = 1 -> parity bit 0; frame is 11 bits.
REQ-036 DATA_BITS = 7, STOP_BITS = 2, push 0x55 -> 1+7+2 bits = 200 cycles at CLK_DIV = 20; stop high for 40 cycles.
REQ-037 Push 6 words on consecutive cycles into an idle block (FIFO_DEPTH = 4) -> 5 words accepted, s_ready low on the 6th; the 6th is accepted at the first frame's end; 6 frames are sent back-to-back with no gaps and in order.
REQ-038 Assert rst for 1 cycle mid-DATA with 2 words queued -> uart_tx = 1 at once; fifo_count = 0; no further frames until a new push.
